// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants for the LED PWM port.
// Control register layout, reset value and register index helper.
package led_pwm_pkg;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_SYNC_BIT = 1;
  localparam int CTRL_BITS     = 2;

  localparam logic [CTRL_BITS-1:0] CTRL_RESET = 2'b11;

  // Control register sits right after the last duty register.
  function automatic int ctrl_index(input int channels);
    return channels;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, PWM period counter and wrap detector.
// Everything is held at zero while run is low.
module pwm_timebase #(
  parameter int PRESCALE   = 188,
  parameter int DUTY_WIDTH = 8
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic                  run,
  output logic [DUTY_WIDTH-1:0] cnt,
  output logic                  period_start
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);

  logic [PW-1:0]         r_pre;
  logic                  r_tick;
  logic [DUTY_WIDTH-1:0] r_cnt;
  logic                  w_wrap;
  logic                  w_cnt_max;

  assign w_wrap    = run && (r_pre == PRE_MAX);
  assign w_cnt_max = &r_cnt;

  // Tick is registered off the prescaler wrap, so after a
  // restart the first count step lands PRESCALE cycles out.
  always_ff @(posedge clk_48mhz) begin
    if (reset || !run) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_pre  <= w_wrap ? '0 : r_pre + 1'b1;
      r_tick <= w_wrap;
      if (r_tick)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt          = r_cnt;
  assign period_start = run && r_tick && w_cnt_max;

endmodule

// File: rtl/led_pwm_port.sv
// led_pwm_port: N-channel PWM LED port on the register bus.
// Double-buffered duties, per-channel polarity, registered outputs.
module led_pwm_port
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int DUTY_WIDTH = 8,
  parameter int PRESCALE   = 188,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW = '0,
  localparam int ADDR_WIDTH = $clog2(CHANNELS + 1)
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DUTY_WIDTH-1:0] wr_data,
  output logic [DUTY_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  period_start,
  output logic [CHANNELS-1:0]   pwm_out
);

  localparam int CTRL_IDX = ctrl_index(CHANNELS);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_ch
    $error("CHANNELS must be 1..32");
  end
  if (DUTY_WIDTH < 2 || DUTY_WIDTH > 16) begin : g_bad_dw
    $error("DUTY_WIDTH must be 2..16");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_ps
    $error("PRESCALE must be 1..65535");
  end

  logic [DUTY_WIDTH-1:0] r_shadow [CHANNELS];
  logic [DUTY_WIDTH-1:0] r_active [CHANNELS];
  logic [CTRL_BITS-1:0]  r_ctrl;
  logic [CHANNELS-1:0]   r_pwm;
  logic [DUTY_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic [CHANNELS-1:0]   w_wr_ch;
  logic                  w_wr_ctrl;
  logic                  w_run;
  logic                  w_sync;
  logic                  w_track;
  logic                  w_ps;
  logic [DUTY_WIDTH-1:0] w_cnt;
  logic [CHANNELS-1:0]   w_on;
  logic [DUTY_WIDTH-1:0] w_rd_mux;

  assign w_run   = r_ctrl[CTRL_RUN_BIT];
  assign w_sync  = r_ctrl[CTRL_SYNC_BIT];
  assign w_track = !w_run || !w_sync;

  assign w_wr_ctrl =
    wr_en && (addr == ADDR_WIDTH'(CTRL_IDX));

  always_comb begin
    w_wr_ch = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_wr_ch[i] = wr_en && (addr == ADDR_WIDTH'(i));
  end

  pwm_timebase #(
    .PRESCALE   (PRESCALE),
    .DUTY_WIDTH (DUTY_WIDTH)
  ) u_timebase (
    .clk_48mhz    (clk_48mhz),
    .reset        (reset),
    .run          (w_run),
    .cnt          (w_cnt),
    .period_start (w_ps)
  );

  always_ff @(posedge clk_48mhz) begin
    if (reset)
      r_ctrl <= CTRL_RESET;
    else if (w_wr_ctrl)
      r_ctrl <= wr_data[CTRL_BITS-1:0];
  end

  // At a wrap a same-cycle write bypasses the shadow so the
  // new duty governs the period that is just starting.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wr_ch[i])
          r_shadow[i] <= wr_data;
        if (w_track)
          r_active[i] <= r_shadow[i];
        else if (w_ps)
          r_active[i] <= w_wr_ch[i] ? wr_data
                                    : r_shadow[i];
      end
    end
  end

  always_comb begin
    w_on = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_on[i] = (&r_active[i]) ||
                (w_cnt < r_active[i]);
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset)
      r_pwm <= ACTIVE_LOW;
    else
      r_pwm <= ({CHANNELS{w_run}} & w_on) ^ ACTIVE_LOW;
  end

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (addr == ADDR_WIDTH'(i))
        w_rd_mux = r_shadow[i];
    if (addr == ADDR_WIDTH'(CTRL_IDX))
      w_rd_mux[CTRL_BITS-1:0] = r_ctrl;
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en)
        r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign period_start = w_ps;
  assign pwm_out      = r_pwm;

endmodule
